// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encoding, zero-register id, default timeout, saturating increment.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [4:0] ZERO_REG = 5'd0;

    localparam int MEM_TIMEOUT_DEF = 64;
    localparam int TO_W_DEF        = 7;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Sequencer for IDLE/RUN/MEM_WAIT with the data-memory handshake,
// watchdog counter, per-instruction done flag and sticky error.
module mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int TO_W        = TO_W_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   start,
    input  logic   req,
    input  logic   ack,
    output state_t state,
    output logic   issue,
    output logic   err
);

    localparam logic [TO_W-1:0] LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t          state_nxt;
    logic [TO_W-1:0] cnt;
    logic [TO_W-1:0] cnt_nxt;
    logic            done;
    logic            done_nxt;
    logic            err_nxt;

    // State, watchdog, done flag and error flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

    // Next-state logic; a held MEM-stage access is issued only once
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = done;
        err_nxt   = err;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                if (req && !done) begin
                    issue     = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = MEM_WAIT;
                end else begin
                    // pipeline advances this cycle, so EX/MEM changes
                    done_nxt = 1'b0;
                    if (!start) state_nxt = IDLE;
                end
            end
            MEM_WAIT: begin
                if (ack) begin
                    done_nxt  = 1'b1;
                    state_nxt = start ? RUN : IDLE;
                end else if (cnt == LAST) begin
                    err_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = start ? RUN : IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, load-use bubble, branch flush.
// Optional event counters are enabled with HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int TO_W        = TO_W_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        Start_i,
    input  logic        IdEx_MemRead_i,
    input  logic [4:0]  IdEx_rt_i,
    input  logic [4:0]  IfId_rs_i,
    input  logic [4:0]  IfId_rt_i,
    input  logic        Branch_taken_i,
    input  logic        ExMem_MemReq_i,
    input  logic        DMem_ack_i,
    output logic        PC_write_o,
    output logic        IfId_write_o,
    output logic        IfId_flush_o,
    output logic        IdEx_bubble_o,
    output logic        Pipe_stall_o,
    output logic        DMem_start_o,
    output logic        Mem_err_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] Cnt_loaduse_o,
    output logic [31:0] Cnt_flush_o,
    output logic [31:0] Cnt_memwait_o
`endif
);

    state_t state;
    logic   issue;
    logic   hit;

    mem_wait_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_fsm (
        .clk   (clk_i),
        .rst_n (rst_i),
        .start (Start_i),
        .req   (ExMem_MemReq_i),
        .ack   (DMem_ack_i),
        .state (state),
        .issue (issue),
        .err   (Mem_err_o)
    );

    assign DMem_start_o = issue;

    assign hit = IdEx_MemRead_i
              && (IdEx_rt_i != ZERO_REG)
              && ((IdEx_rt_i == IfId_rs_i)
               || (IdEx_rt_i == IfId_rt_i));

    // Priority: memory freeze, then load-use bubble, then branch flush
    always_comb begin
        PC_write_o    = 1'b0;
        IfId_write_o  = 1'b0;
        IfId_flush_o  = 1'b0;
        IdEx_bubble_o = 1'b0;
        Pipe_stall_o  = 1'b1;
        if (state == RUN) begin
            if (!issue) begin
                Pipe_stall_o = 1'b0;
                if (hit) begin
                    IdEx_bubble_o = 1'b1;
                end else begin
                    PC_write_o   = 1'b1;
                    IfId_write_o = 1'b1;
                    IfId_flush_o = Branch_taken_i;
                end
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating event counters for bubbles, flushes and wait cycles
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            Cnt_loaduse_o <= '0;
            Cnt_flush_o   <= '0;
            Cnt_memwait_o <= '0;
        end else begin
            if (IdEx_bubble_o)
                Cnt_loaduse_o <= sat_inc(Cnt_loaduse_o);
            if (IfId_flush_o)
                Cnt_flush_o <= sat_inc(Cnt_flush_o);
            if (state == MEM_WAIT)
                Cnt_memwait_o <= sat_inc(Cnt_memwait_o);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard scenarios followed
// by randomized traffic against a cycle-level reference model.
module tb_hazard_ctrl;

    localparam int TMO = 8;

    typedef struct {
        logic        pcw;
        logic        ifw;
        logic        flush;
        logic        bub;
        logic        stall;
        logic        start;
        logic        err;
        logic [31:0] c_lu;
        logic [31:0] c_fl;
        logic [31:0] c_mw;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        Start_i = 1'b0;
    logic        IdEx_MemRead_i = 1'b0;
    logic [4:0]  IdEx_rt_i = '0;
    logic [4:0]  IfId_rs_i = '0;
    logic [4:0]  IfId_rt_i = '0;
    logic        Branch_taken_i = 1'b0;
    logic        ExMem_MemReq_i = 1'b0;
    logic        DMem_ack_i = 1'b0;
    logic        PC_write_o;
    logic        IfId_write_o;
    logic        IfId_flush_o;
    logic        IdEx_bubble_o;
    logic        Pipe_stall_o;
    logic        DMem_start_o;
    logic        Mem_err_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] Cnt_loaduse_o;
    logic [31:0] Cnt_flush_o;
    logic [31:0] Cnt_memwait_o;
`endif

    hazard_ctrl #(
        .MEM_TIMEOUT (TMO),
        .TO_W        (4)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .Start_i        (Start_i),
        .IdEx_MemRead_i (IdEx_MemRead_i),
        .IdEx_rt_i      (IdEx_rt_i),
        .IfId_rs_i      (IfId_rs_i),
        .IfId_rt_i      (IfId_rt_i),
        .Branch_taken_i (Branch_taken_i),
        .ExMem_MemReq_i (ExMem_MemReq_i),
        .DMem_ack_i     (DMem_ack_i),
        .PC_write_o     (PC_write_o),
        .IfId_write_o   (IfId_write_o),
        .IfId_flush_o   (IfId_flush_o),
        .IdEx_bubble_o  (IdEx_bubble_o),
        .Pipe_stall_o   (Pipe_stall_o),
        .DMem_start_o   (DMem_start_o),
        .Mem_err_o      (Mem_err_o)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .Cnt_loaduse_o  (Cnt_loaduse_o),
        .Cnt_flush_o    (Cnt_flush_o),
        .Cnt_memwait_o  (Cnt_memwait_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // reference model: mode 0=idle 1=running 2=waiting on memory
    int          m_mode = 0;
    int          m_wait = 0;
    bit          m_done = 0;
    bit          m_err  = 0;
    logic [31:0] m_lu = '0;
    logic [31:0] m_fl = '0;
    logic [31:0] m_mw = '0;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   win    = 0;
    int   w_start = 0;
    int   w_stall = 0;

    function automatic logic [31:0] bump(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic exp_t model();
        exp_t e;
        bit   lu;
        bit   acc;
        e = '{pcw: 0, ifw: 0, flush: 0, bub: 0, stall: 1,
              start: 0, err: 0, c_lu: 0, c_fl: 0, c_mw: 0};
        if (!rst_i) begin
            m_mode = 0; m_wait = 0; m_done = 0; m_err = 0;
            m_lu = '0; m_fl = '0; m_mw = '0;
            return e;
        end
        e.err  = m_err;
        e.c_lu = m_lu;
        e.c_fl = m_fl;
        e.c_mw = m_mw;
        lu = IdEx_MemRead_i && (IdEx_rt_i != 0)
          && (IdEx_rt_i == IfId_rs_i || IdEx_rt_i == IfId_rt_i);
        acc = ExMem_MemReq_i && !m_done;
        if (m_mode == 0) begin
            if (Start_i) m_mode = 1;
        end else if (m_mode == 1) begin
            if (acc) begin
                e.start = 1;
                m_mode  = 2;
                m_wait  = 0;
            end else begin
                e.stall = 0;
                m_done  = 0;
                if (lu) begin
                    e.bub = 1;
                    m_lu  = bump(m_lu);
                end else begin
                    e.pcw   = 1;
                    e.ifw   = 1;
                    e.flush = Branch_taken_i;
                    if (Branch_taken_i) m_fl = bump(m_fl);
                end
                if (!Start_i) m_mode = 0;
            end
        end else begin
            m_mw = bump(m_mw);
            if (DMem_ack_i || m_wait == TMO - 1) begin
                if (!DMem_ack_i) m_err = 1;
                m_done = 1;
                m_mode = Start_i ? 1 : 0;
            end else begin
                m_wait++;
            end
        end
        return e;
    endfunction

    task automatic check(input string nm,
                         input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h",
                     nm, cyc, got, want);
        end
    endtask

    task automatic step(input bit st, input bit mr,
                        input logic [4:0] xr, input logic [4:0] rs,
                        input logic [4:0] rt, input bit br,
                        input bit rq, input bit ak);
        @(posedge clk_i);
        #1;
        Start_i        = st;
        IdEx_MemRead_i = mr;
        IdEx_rt_i      = xr;
        IfId_rs_i      = rs;
        IfId_rt_i      = rt;
        Branch_taken_i = br;
        ExMem_MemReq_i = rq;
        DMem_ack_i     = ak;
        q.push_back(model());
    endtask

    task automatic set_rst(input logic v);
        @(posedge clk_i);
        #1;
        rst_i = v;
        q.push_back(model());
    endtask

    // monitor: compares DUT outputs each cycle with the oldest expectation
    always @(negedge clk_i) begin
        exp_t e;
        cyc++;
        if (win) begin
            if (DMem_start_o) w_start++;
            if (Pipe_stall_o) w_stall++;
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            check("outs",
                  {25'd0, PC_write_o, IfId_write_o, IfId_flush_o,
                   IdEx_bubble_o, Pipe_stall_o, DMem_start_o, Mem_err_o},
                  {25'd0, e.pcw, e.ifw, e.flush, e.bub, e.stall,
                   e.start, e.err});
`ifdef HAZARD_PERF_CNT_EN
            check("cnt_lu", Cnt_loaduse_o, e.c_lu);
            check("cnt_fl", Cnt_flush_o, e.c_fl);
            check("cnt_mw", Cnt_memwait_o, e.c_mw);
`endif
        end
    end

    initial begin
        // reset held for a few cycles
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
        set_rst(1'b1);
        // start: one idle cycle then running, no hazards
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 2, 0, 0, 0);
        // load-use on rs, one bubble cycle
        step(1, 1, 8, 8, 3, 0, 0, 0);
        step(1, 0, 8, 8, 3, 0, 0, 0);
        // load-use on rt
        step(1, 1, 9, 1, 9, 0, 0, 0);
        // load into r0 never stalls
        step(1, 1, 0, 0, 0, 0, 0, 0);
        // load-use with taken branch, then branch alone
        step(1, 1, 4, 4, 0, 1, 0, 0);
        step(1, 0, 4, 4, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        // memory access acknowledged on fifth wait cycle
        win = 1;
        step(1, 1, 5, 5, 0, 1, 1, 0);
        repeat (4) step(1, 1, 5, 5, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        #1;
        win = 0;
        check("ack_start_pulses", w_start, 1);
        check("ack_stall_cycles", w_stall, 6);
        // no acknowledge: watchdog fires after TMO wait cycles
        step(1, 0, 0, 0, 0, 0, 1, 0);
        repeat (TMO) step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk_i);
        #1;
        check("err_sticky", {31'd0, Mem_err_o}, 1);
        // stop while waiting: finish handshake, then idle
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // async reset in the middle of a wait
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        set_rst(1'b0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        set_rst(1'b1);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 19) != 0,
                 $urandom_range(0, 9) < 3,
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 6) == 0,
                 $urandom_range(0, 3) == 0);
        end
        repeat (2) @(negedge clk_i);
        #1;
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core; sits beside the forwarding unit and drives PC, IF/ID, ID/EX and global pipeline-register enables.
- Resolves the three hazards forwarding cannot cover:
  - load-use stall (1 bubble)
  - taken-branch IF/ID flush
  - multi-cycle data-memory access, which freezes the whole pipeline via a start/ack handshake with a watchdog timeout.

Parameters:
- MEM_TIMEOUT, 64, max cycles to wait for DMem_ack_i before flagging an error and releasing the stall
- TO_W, 7, width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT

Ports:
- clk_i  in  1  core clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- Start_i  in  1  core enable; pipeline frozen while low
- IdEx_MemRead_i  in  1  instruction in EX is a load
- IdEx_rt_i  in  5  load destination register in EX
- IfId_rs_i  in  5  rs of instruction in ID
- IfId_rt_i  in  5  rt of instruction in ID
- Branch_taken_i  in  1  branch in ID resolved taken
- ExMem_MemReq_i  in  1  instruction in MEM reads or writes data memory
- DMem_ack_i  in  1  data memory completed access (1-cycle pulse)
- PC_write_o  out  1  PC register enable
- IfId_write_o  out  1  IF/ID register enable
- IfId_flush_o  out  1  zero IF/ID on next edge
- IdEx_bubble_o  out  1  insert NOP controls into ID/EX
- Pipe_stall_o  out  1  freeze ID/EX, EX/MEM, MEM/WB
- DMem_start_o  out  1  1-cycle request pulse to data memory
- Mem_err_o  out  1  sticky timeout flag

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE, wait counter=0, mem_done=0, Mem_err_o=0
  - PC_write_o=0, IfId_write_o=0, Pipe_stall_o=1
  - IfId_flush_o=0, IdEx_bubble_o=0, DMem_start_o=0
- IDLE:
  - outputs hold their reset values
  - Start_i=1 -> RUN on next edge
- RUN, default: PC_write_o=1, IfId_write_o=1, all other outputs 0.
- RUN, memory access (highest priority): if ExMem_MemReq_i=1 and mem_done=0:
  - DMem_start_o=1 this cycle
  - Pipe_stall_o=1, PC_write_o=0, IfId_write_o=0
  - flush and bubble suppressed
  - -> MEM_WAIT, counter cleared
- RUN, load-use (priority 2): if IdEx_MemRead_i=1, IdEx_rt_i!=0 and IdEx_rt_i equals IfId_rs_i or IfId_rt_i:
  - PC_write_o=0, IfId_write_o=0, IdEx_bubble_o=1
  - IfId_flush_o forced 0; the branch is re-evaluated next cycle
- RUN, taken branch (priority 3): Branch_taken_i=1 -> IfId_flush_o=1; PC_write_o stays 1.
- MEM_WAIT:
  - Pipe_stall_o=1, PC_write_o=0, IfId_write_o=0; counter increments each cycle
  - DMem_ack_i=1 -> RUN, mem_done set; the stall releases the cycle after ack
  - counter reaching MEM_TIMEOUT-1 without ack -> Mem_err_o set (sticky until reset), mem_done set, -> RUN
- mem_done:
  - prevents re-issue for the same instruction, since EX/MEM is held during the wait
  - cleared on the first RUN cycle in which Pipe_stall_o=0, i.e. when EX/MEM advances
- Start_i deasserted:
  - in RUN -> IDLE at the next edge
  - in MEM_WAIT -> finish the handshake first, then IDLE
- DMem_ack_i outside MEM_WAIT is ignored.
- All outputs are combinational from state, registered flags and current inputs; there is no added latency.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds three 32-bit outputs:
  - Cnt_loaduse_o: cycles with load-use bubble
  - Cnt_flush_o: branch flushes
  - Cnt_memwait_o: cycles spent in MEM_WAIT
- Counters reset to 0, saturate at 32'hFFFFFFFF, count only when the event is asserted, and have no clear input.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - state encoding IDLE=2'd0, RUN=2'd1, MEM_WAIT=2'd2
  - the zero-register constant 5'd0
  - the default MEM_TIMEOUT
- One sub-module, mem_wait_fsm: owns the state register, wait counter, mem_done, Mem_err_o and DMem_start_o.
- The top level adds the combinational load-use/branch priority logic and the optional counters.

Test Plan:
- Reset then Start_i=1, no hazards -> IDLE->RUN in 1 cycle; PC_write_o=1, IfId_write_o=1, Pipe_stall_o=0.
- IdEx_MemRead_i=1, IdEx_rt_i=5'd8, IfId_rs_i=5'd8 -> exactly one cycle with PC_write_o=0, IdEx_bubble_o=1; with IdEx_rt_i=0 -> no stall.
- Load-use and Branch_taken_i in the same cycle -> IfId_flush_o=0 that cycle; on the next cycle (no load-use) -> IfId_flush_o=1.
- ExMem_MemReq_i=1, DMem_ack_i after 5 cycles:
  - one DMem_start_o pulse
  - Pipe_stall_o=1 for 6 cycles
  - no second pulse while EX/MEM is still held
- No ack with MEM_TIMEOUT=8 -> Mem_err_o=1 after 8 wait cycles, return to RUN, flag stays 1 until rst_i=0.
- rst_i=0 asserted mid-MEM_WAIT (asynchronous) -> immediate IDLE, all outputs at reset values, Mem_err_o=0.
